// File: rtl/hex_scroll_ctrl.sv
// Scrolling six-character message controller driving the board HEX digits and status LEDs.
// Optional macro HEX_SCROLL_DP_EN lights the hex5 decimal point while the window starts at buffer index 0.
module hex_scroll_ctrl #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 100,
    parameter int DEB_TICKS = 2,
    parameter int MSG_DEPTH = 16
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [4:0] wr_char,
    input  logic [4:0] msg_len,
    input  logic [3:0] speed,
    input  logic [1:0] button,
    output logic [7:0] hex5,
    output logic [7:0] hex4,
    output logic [7:0] hex3,
    output logic [7:0] hex2,
    output logic [7:0] hex1,
    output logic [7:0] hex0,
    output logic [9:0] led
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW  = $clog2(DEB_TICKS + 1);

    function automatic logic [7:0] seg7(input logic [4:0] c);
        case (c)
            5'd0:  seg7 = 8'hC0;  5'd1:  seg7 = 8'hF9;  5'd2:  seg7 = 8'hA4;  5'd3:  seg7 = 8'hB0;
            5'd4:  seg7 = 8'h99;  5'd5:  seg7 = 8'h92;  5'd6:  seg7 = 8'h82;  5'd7:  seg7 = 8'hF8;
            5'd8:  seg7 = 8'h80;  5'd9:  seg7 = 8'h90;  5'd10: seg7 = 8'h88;  5'd11: seg7 = 8'h83;
            5'd12: seg7 = 8'hC6;  5'd13: seg7 = 8'hA1;  5'd14: seg7 = 8'h86;  5'd15: seg7 = 8'h8E;
            5'd16: seg7 = 8'h89;  5'd17: seg7 = 8'hC7;  5'd18: seg7 = 8'h8C;  5'd19: seg7 = 8'hC1;
            5'd20: seg7 = 8'hAF;  5'd21: seg7 = 8'hAB;  5'd22: seg7 = 8'hBF;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    logic [4:0]         mem_q [MSG_DEPTH];
    logic [PW-1:0]      pre_q, pre_d;
    logic [1:0]         sync1_q, sync2_q;
    logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]         acc_q, acc_d;
    logic [6:0]         step_cnt_q, step_cnt_d;
    logic [6:0]         step_last_q, step_last_d;
    logic [3:0]         ptr_q, ptr_d;
    logic               dir_q, dir_d;
    logic               paused_q, paused_d;
    logic [5:0][7:0]    hex_q, hex_d;
    logic [9:0]         led_q, led_d;

    logic       tick;
    logic       step;
    logic [1:0] press;
    logic [4:0] len_c;
    logic [4:0] len_div;
    logic [3:0] win;

    // NOTE: every variable assigned in always_comb gets a default first so no latch can be inferred.
    always_comb begin
        tick        = 1'b0;
        pre_d       = pre_q + 1'b1;
        deb_cnt_d   = deb_cnt_q;
        acc_d       = acc_q;
        press       = 2'b00;
        step        = 1'b0;
        step_cnt_d  = step_cnt_q;
        step_last_d = step_last_q;

        if (pre_q == PW'(DIV - 1)) begin
            tick  = 1'b1;
            pre_d = '0;
        end

        // A button level is accepted once DEB_TICKS tick samples in a row disagree with the old level.
        for (int b = 0; b < 2; b++) begin
            if (tick) begin
                if (sync2_q[b] == acc_q[b]) begin
                    deb_cnt_d[b] = '0;
                end else if (deb_cnt_q[b] == DW'(DEB_TICKS - 1)) begin
                    deb_cnt_d[b] = '0;
                    acc_d[b]     = sync2_q[b];
                    press[b]     = ~sync2_q[b];
                end else begin
                    deb_cnt_d[b] = deb_cnt_q[b] + 1'b1;
                end
            end
        end

        // Period in ticks is (16 - speed) * 8; the last count index is therefore {~speed, 3'b111}.
        if (tick) begin
            if (step_cnt_q == step_last_q) begin
                step        = 1'b1;
                step_cnt_d  = '0;
                step_last_d = {~speed, 3'b111};
            end else begin
                step_cnt_d = step_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        len_c    = (msg_len > 5'(MSG_DEPTH)) ? 5'(MSG_DEPTH) : msg_len;
        len_div  = (len_c == 5'd0) ? 5'd1 : len_c;
        paused_d = paused_q ^ press[0];
        dir_d    = dir_q ^ press[1];
        ptr_d    = ptr_q;
        win      = '0;
        hex_d    = '1;

        if (len_c == 5'd0 || {1'b0, ptr_q} >= len_c) begin
            ptr_d = '0;
        end else if (step && !paused_q && !press[0]) begin
            if (dir_q) ptr_d = (ptr_q == 4'd0) ? 4'(len_c - 5'd1) : ptr_q - 1'b1;
            else       ptr_d = ({1'b0, ptr_q} == len_c - 5'd1) ? 4'd0 : ptr_q + 1'b1;
        end

        if (len_c != 5'd0) begin
            for (int k = 0; k < 6; k++) begin
                win          = 4'(({1'b0, ptr_q} + 5'(k)) % len_div);
                hex_d[5 - k] = seg7(mem_q[win]);
            end
`ifdef HEX_SCROLL_DP_EN
            if (ptr_q == 4'd0) hex_d[5][7] = 1'b0;
`endif
        end

        led_d = {paused_q, dir_q, 3'b000, 1'b0, ptr_q};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            pre_q       <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_cnt_q   <= '0;
            acc_q       <= '0;
            step_cnt_q  <= '0;
            step_last_q <= {~speed, 3'b111};
            ptr_q       <= '0;
            dir_q       <= 1'b0;
            paused_q    <= 1'b0;
            hex_q       <= '1;
            led_q       <= '0;
        end else begin
            pre_q       <= pre_d;
            sync1_q     <= button;
            sync2_q     <= sync1_q;
            deb_cnt_q   <= deb_cnt_d;
            acc_q       <= acc_d;
            step_cnt_q  <= step_cnt_d;
            step_last_q <= step_last_d;
            ptr_q       <= ptr_d;
            dir_q       <= dir_d;
            paused_q    <= paused_d;
            hex_q       <= hex_d;
            led_q       <= led_d;
        end
    end

    // NOTE: the message buffer has no reset so its contents survive a reset of the controller.
    always_ff @(posedge clk_clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_char;
    end

    assign hex5 = hex_q[5];
    assign hex4 = hex_q[4];
    assign hex3 = hex_q[3];
    assign hex2 = hex_q[2];
    assign hex1 = hex_q[1];
    assign hex0 = hex_q[0];
    assign led  = led_q;

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Self-checking bench for hex_scroll_ctrl: a message-level model checked every cycle plus directed literals.
module tb_hex_scroll_ctrl;
    localparam int CLK_HZ    = 1000;
    localparam int TICK_HZ   = 100;
    localparam int DEB_TICKS = 2;
    localparam int DIV       = CLK_HZ / TICK_HZ;

`ifdef HEX_SCROLL_DP_EN
    localparam logic [7:0] H_AT0 = 8'h09;
`else
    localparam logic [7:0] H_AT0 = 8'h89;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [4:0] wr_char;
    logic [4:0] msg_len;
    logic [3:0] speed;
    logic [1:0] button;
    logic [7:0] hex5, hex4, hex3, hex2, hex1, hex0;
    logic [9:0] led;
    logic [47:0] hex_all;

    assign hex_all = {hex5, hex4, hex3, hex2, hex1, hex0};

    always #5 clk = ~clk;

    hex_scroll_ctrl #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEB_TICKS(DEB_TICKS), .MSG_DEPTH(16)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_char(wr_char), .msg_len(msg_len), .speed(speed), .button(button),
        .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
        .led(led)
    );

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [4:0]           m_buf [16];
    int                   m_ptr, m_edges, m_ticks, m_next, m_period;
    logic                 m_dir, m_paused;
    logic [1:0]           m_sync1, m_sync2, m_acc;
    logic [DEB_TICKS-1:0] m_hist [2];
    logic [47:0]          exp_hex;
    logic [9:0]           exp_led;

    function automatic logic [7:0] seg_of(input logic [4:0] c);
        logic [7:0] t [23];
        t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90,
              8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E,
              8'h89, 8'hC7, 8'h8C, 8'hC1, 8'hAF, 8'hAB, 8'hBF};
        return (int'(c) < 23) ? t[c] : 8'hFF;
    endfunction

    function automatic logic [47:0] model_window(input int p, input int len);
        logic [47:0] w;
        w = '1;
        if (len == 0) return w;
        for (int k = 0; k < 6; k++) w[(5 - k) * 8 +: 8] = seg_of(m_buf[(p + k) % len]);
`ifdef HEX_SCROLL_DP_EN
        if (p == 0) w[47] = 1'b0;
`endif
        return w;
    endfunction

    task automatic model_step();
        int len;
        logic is_tick, is_step;
        logic [1:0] smp, ev;
        len = (int'(msg_len) > 16) ? 16 : int'(msg_len);
        if (!rst_n) begin
            exp_hex  = '1;
            exp_led  = '0;
            m_ptr    = 0;
            m_dir    = 1'b0;
            m_paused = 1'b0;
            m_edges  = 0;
            m_ticks  = 0;
            m_period = (16 - int'(speed)) * 8;
            m_next   = m_period;
            m_sync1  = '0;
            m_sync2  = '0;
            m_acc    = '0;
            m_hist[0] = '0;
            m_hist[1] = '0;
        end else begin
            exp_hex = model_window(m_ptr, len);
            exp_led = {m_paused, m_dir, 3'b000, 5'(m_ptr)};
            is_tick = (m_edges % DIV) == DIV - 1;
            m_edges++;
            smp     = m_sync2;
            ev      = '0;
            is_step = 1'b0;
            if (is_tick) begin
                m_ticks++;
                for (int b = 0; b < 2; b++) begin
                    m_hist[b] = (m_hist[b] << 1) | DEB_TICKS'(smp[b]);
                    if ((m_hist[b] == '0 || m_hist[b] == '1) && smp[b] != m_acc[b]) begin
                        m_acc[b] = smp[b];
                        ev[b]    = ~smp[b];
                    end
                end
                if (m_ticks == m_next) begin
                    is_step  = 1'b1;
                    m_period = (16 - int'(speed)) * 8;
                    m_next   = m_next + m_period;
                end
            end
            if (len == 0 || m_ptr >= len) m_ptr = 0;
            else if (is_step && !m_paused && !ev[0])
                m_ptr = m_dir ? (m_ptr + len - 1) % len : (m_ptr + 1) % len;
            m_paused = m_paused ^ ev[0];
            m_dir    = m_dir ^ ev[1];
            m_sync2  = m_sync1;
            m_sync1  = button;
        end
        if (wr_en) m_buf[wr_addr] = wr_char;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_buf[i] = '0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    always @(negedge clk) begin
        if (check_en) check("cycle_model", {hex_all, led}, {exp_hex, exp_led});
    end

    // ---------------- directed stimulus ----------------
    task automatic press(input int b, input int low_cyc, input int high_cyc);
        button[b] = 1'b0;
        repeat (low_cyc) @(negedge clk);
        button[b] = 1'b1;
        repeat (high_cyc) @(negedge clk);
    endtask

    task automatic wait_ptr(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (led[4:0] !== 5'(target) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, led[4:0], 5'(target));
    endtask

    task automatic write_char(input int addr, input int code);
        wr_en   = 1'b1;
        wr_addr = 4'(addr);
        wr_char = 5'(code);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int codes [6];
        int frozen;
        codes   = '{16, 14, 17, 17, 0, 23};
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_char = '0;
        msg_len = '0;
        speed   = 4'd15;
        button  = 2'b11;
        @(negedge clk);
        check_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_hex", hex_all, 48'hFFFF_FFFF_FFFF);
        check("reset_led", led, 10'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) write_char(i, codes[i]);
        for (int i = 6; i < 15; i++) write_char(i, i - 5);
        write_char(15, 10);
        msg_len = 5'd6;
        repeat (2) @(negedge clk);
        check("hello_ptr0", hex_all, {H_AT0, 40'h86_C7_C7_C0_FF});
        check("hello_led", led, 10'd0);

        wait_ptr(1, 200, "first_step_ptr");
        check("hello_ptr1", hex_all, 48'h86_C7_C7_C0_FF_89);

        wr_en = 1'b1; wr_addr = 4'd3; wr_char = 5'd22;
        @(negedge clk);
        wr_en = 1'b0;
        check("write_lat_before", hex3, 8'hC7);
        @(negedge clk);
        check("write_lat_after", hex3, 8'hBF);
        write_char(3, 17);

        wait_ptr(5, 500, "reach_ptr5");
        msg_len = 5'd3;
        repeat (2) @(negedge clk);
        check("len_shrink_ptr", led[4:0], 5'd0);
        check("len3_window", hex_all, {H_AT0, 40'h86_C7_89_86_C7});
        msg_len = 5'd0;
        repeat (2) @(negedge clk);
        check("len0_hex", hex_all, 48'hFFFF_FFFF_FFFF);
        check("len0_ptr", led[4:0], 5'd0);
        msg_len = 5'd6;

        press(0, 10, 50);
        check("bounce_no_pause", led[9], 1'b0);
        press(0, 30, 10);
        check("pause_on", led[9], 1'b1);
        frozen = m_ptr;
        repeat (5000) @(negedge clk);
        check("pause_frozen", led[4:0], 5'(frozen));
        press(0, 30, 10);
        check("pause_off", led[9], 1'b0);

        wait_ptr(5, 700, "pre_dir_ptr5");
        wait_ptr(0, 200, "pre_dir_ptr0");
        press(1, 30, 10);
        check("dir_on", led[8], 1'b1);
        check("dir_ptr_hold", led[4:0], 5'd0);
        wait_ptr(5, 200, "reverse_wrap_ptr5");

        for (int i = 0; i < 8; i++) press(0, 30, 60);
        for (int i = 0; i < 8; i++) press(1, 30, 60);
        check("collide_paused", led[9], 1'b0);
        check("collide_dir", led[8], 1'b1);

        speed = 4'd12;
        repeat (1000) @(negedge clk);
        speed = 4'd15;

        msg_len = 5'd20;
        wait_ptr(12, 1500, "clamp_ptr12");
        check("clamp_window", hex_all, 48'hF8_80_90_88_89_86);

        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_hex", hex_all, 48'hFFFF_FFFF_FFFF);
        check("midreset_led", led, 10'd0);
        msg_len = 5'd6;
        rst_n   = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_window", hex_all, {H_AT0, 40'h86_C7_C7_C0_FF});
        check("post_reset_led", led, 10'd0);
        repeat (200) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
